bus_mux_reg: RTL and testbench

//  Parametrised successor to the datapath bus multiplexer: NUM_SRC sources of WIDTH bits

---
 rtl/cpu_bus_pkg.sv | 39 +++
 rtl/bus_src_encoder.sv | 27 ++
 rtl/bus_mux_reg.sv | 103 ++++++++++
 tb/tb_bus_mux_reg.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: default bus geometry, bus source indices and
// the index-width helper used by the bus multiplexer and its encoder.
package cpu_bus_pkg;

  localparam int BUS_WIDTH   = 32;
  localparam int BUS_NUM_SRC = 24;

  // Bus source positions in the flattened source vector / out-enable word.
  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_RA     = 10;
  localparam int SRC_RB     = 11;
  localparam int SRC_RC     = 12;
  localparam int SRC_RD     = 13;
  localparam int SRC_RE     = 14;
  localparam int SRC_RF     = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // A single source still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_src_encoder.sv
// One-hot out-enable encoder: lowest asserted enable wins, plus any/multi flags.
module bus_src_encoder
  import cpu_bus_pkg::*;
#(
  parameter int NUM_SRC = BUS_NUM_SRC,
  parameter int IDX_W   = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] src_out,
  output logic [IDX_W-1:0]   winner,
  output logic               any_en,
  output logic               multi
);

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) winner = i[IDX_W-1:0];
    end
  end

  assign any_en = |src_out;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi  = |(src_out & (src_out - NUM_SRC'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// CPU internal bus multiplexer with keeper register, optional registered
// output, conflict detection and a saturating transfer counter.
module bus_mux_reg
  import cpu_bus_pkg::*;
#(
  parameter int WIDTH      = BUS_WIDTH,
  parameter int NUM_SRC    = BUS_NUM_SRC,
  parameter bit REGISTERED = 1'b1,
  parameter int CNT_W      = 16,
  localparam int IDX_W     = idx_width(NUM_SRC)
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     hold,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [IDX_W-1:0]         sel_idx,
  output logic                     conflict,
  output logic                     conflict_err,
  output logic [CNT_W-1:0]         xfer_count
);

  logic [IDX_W-1:0] winner;
  logic             any_en;
  logic             multi;
  logic [WIDTH-1:0] sel_data;
  logic             take;

  logic [WIDTH-1:0] bus_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  bus_src_encoder #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_encoder (
    .src_out (src_out),
    .winner  (winner),
    .any_en  (any_en),
    .multi   (multi)
  );

  // Explicit compare-and-select so unselected sources can never leak onto the bus.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (winner == IDX_W'(i)) sel_data = src_data[i*WIDTH +: WIDTH];
    end
  end

  assign take = any_en & ~hold;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      bus_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else if (!hold) begin
      if (any_en) begin
        bus_q <= sel_data;
        idx_q <= winner;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end
      err_q <= err_q | multi;
    end
  end

  assign conflict_err = err_q;
  assign xfer_count   = cnt_q;

  if (REGISTERED) begin : g_reg_out
    logic valid_q;
    logic conflict_q;

    always_ff @(posedge clock) begin
      if (clear) begin
        valid_q    <= 1'b0;
        conflict_q <= 1'b0;
      end else if (!hold) begin
        valid_q    <= any_en;
        conflict_q <= multi;
      end
    end

    assign bus_out   = bus_q;
    assign sel_idx   = idx_q;
    assign bus_valid = valid_q;
    assign conflict  = conflict_q;
  end else begin : g_comb_out
    // Live source goes straight through; otherwise the keeper value shows.
    assign bus_out   = take ? sel_data : bus_q;
    assign sel_idx   = take ? winner : idx_q;
    assign bus_valid = take;
    assign conflict  = multi & ~hold;
  end

endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: registered default, 4-bit counter and
// combinational-output variants, each driven by its own stimulus set.
module tb_bus_mux_reg;
  import cpu_bus_pkg::*;

  localparam int W  = 32;
  localparam int N  = 24;
  localparam int IW = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance (REGISTERED=1, CNT_W=16)
  logic           a_clear = 1'b1, a_hold = 1'b0;
  logic [N*W-1:0] a_data = '0;
  logic [N-1:0]   a_src = '0;
  logic [W-1:0]   a_bus;
  logic           a_valid, a_conf, a_err;
  logic [IW-1:0]  a_sel;
  logic [15:0]    a_cnt;

  // Narrow-counter instance (CNT_W=4)
  logic           b_clear = 1'b1, b_hold = 1'b0;
  logic [N*W-1:0] b_data = '0;
  logic [N-1:0]   b_src = '0;
  logic [W-1:0]   b_bus;
  logic           b_valid, b_conf, b_err;
  logic [IW-1:0]  b_sel;
  logic [3:0]     b_cnt;

  // Combinational-output instance (REGISTERED=0)
  logic           c_clear = 1'b1, c_hold = 1'b0;
  logic [N*W-1:0] c_data = '0;
  logic [N-1:0]   c_src = '0;
  logic [W-1:0]   c_bus;
  logic           c_valid, c_conf, c_err;
  logic [IW-1:0]  c_sel;
  logic [15:0]    c_cnt;

  int checks = 0;
  int errors = 0;

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(N), .REGISTERED(1'b1), .CNT_W(16)) dut_a (
    .clock(clock), .clear(a_clear), .src_data(a_data), .src_out(a_src), .hold(a_hold),
    .bus_out(a_bus), .bus_valid(a_valid), .sel_idx(a_sel), .conflict(a_conf),
    .conflict_err(a_err), .xfer_count(a_cnt));

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(N), .REGISTERED(1'b1), .CNT_W(4)) dut_b (
    .clock(clock), .clear(b_clear), .src_data(b_data), .src_out(b_src), .hold(b_hold),
    .bus_out(b_bus), .bus_valid(b_valid), .sel_idx(b_sel), .conflict(b_conf),
    .conflict_err(b_err), .xfer_count(b_cnt));

  bus_mux_reg #(.WIDTH(W), .NUM_SRC(N), .REGISTERED(1'b0), .CNT_W(16)) dut_c (
    .clock(clock), .clear(c_clear), .src_data(c_data), .src_out(c_src), .hold(c_hold),
    .bus_out(c_bus), .bus_valid(c_valid), .sel_idx(c_sel), .conflict(c_conf),
    .conflict_err(c_err), .xfer_count(c_cnt));

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int exp_cnt;

    // Reset state
    step();
    check("a_rst_bus", a_bus, 32'h0);
    check("a_rst_valid", 32'(a_valid), 32'h0);
    check("a_rst_sel", 32'(a_sel), 32'h0);
    check("a_rst_conf", 32'(a_conf), 32'h0);
    check("a_rst_err", 32'(a_err), 32'h0);
    check("a_rst_cnt", 32'(a_cnt), 32'h0);

    // Single transfer from R5, one-cycle latency
    a_clear = 1'b0;
    a_data[SRC_R5*W +: W] = 32'hDEADBEEF;
    a_src = N'(1) << SRC_R5;
    step();
    check("a_r5_bus", a_bus, 32'hDEADBEEF);
    check("a_r5_sel", 32'(a_sel), 32'd5);
    check("a_r5_valid", 32'(a_valid), 32'h1);
    check("a_r5_cnt", 32'(a_cnt), 32'd1);
    check("a_r5_conf", 32'(a_conf), 32'h0);

    // Idle bus: keeper holds value, valid drops, count frozen
    a_src = '0;
    step(); step(); step();
    check("a_keep_bus", a_bus, 32'hDEADBEEF);
    check("a_keep_valid", 32'(a_valid), 32'h0);
    check("a_keep_sel", 32'(a_sel), 32'd5);
    check("a_keep_cnt", 32'(a_cnt), 32'd1);

    // Two drivers: lowest index wins, conflict for one cycle, sticky error
    a_data[SRC_R3*W +: W] = 32'h1;
    a_data[SRC_PC*W +: W] = 32'h2;
    a_src = (N'(1) << SRC_R3) | (N'(1) << SRC_PC);
    step();
    check("a_multi_bus", a_bus, 32'h1);
    check("a_multi_sel", 32'(a_sel), 32'd3);
    check("a_multi_conf", 32'(a_conf), 32'h1);
    check("a_multi_err", 32'(a_err), 32'h1);
    check("a_multi_cnt", 32'(a_cnt), 32'd2);
    a_src = N'(1) << SRC_PC;
    step();
    check("a_pc_bus", a_bus, 32'h2);
    check("a_pc_sel", 32'(a_sel), 32'd20);
    check("a_pc_conf", 32'(a_conf), 32'h0);
    check("a_pc_err_sticky", 32'(a_err), 32'h1);
    check("a_pc_cnt", 32'(a_cnt), 32'd3);

    // Hold freezes everything
    a_hold = 1'b1;
    a_data[SRC_MDR*W +: W] = 32'hCAFE0000;
    a_src = N'(1) << SRC_MDR;
    step();
    check("a_hold_bus", a_bus, 32'h2);
    check("a_hold_sel", 32'(a_sel), 32'd20);
    check("a_hold_cnt", 32'(a_cnt), 32'd3);
    check("a_hold_valid", 32'(a_valid), 32'h1);
    a_hold = 1'b0;
    step();
    check("a_mdr_bus", a_bus, 32'hCAFE0000);
    check("a_mdr_sel", 32'(a_sel), 32'd21);
    check("a_mdr_cnt", 32'(a_cnt), 32'd4);

    // Clear overrides hold with an active source
    a_hold = 1'b1;
    a_clear = 1'b1;
    step();
    check("a_clr_bus", a_bus, 32'h0);
    check("a_clr_sel", 32'(a_sel), 32'h0);
    check("a_clr_valid", 32'(a_valid), 32'h0);
    check("a_clr_err", 32'(a_err), 32'h0);
    check("a_clr_cnt", 32'(a_cnt), 32'h0);

    // Multi-driver while held must not set the sticky error
    a_clear = 1'b0;
    a_data[SRC_R0*W +: W] = 32'h000000A5;
    a_src = (N'(1) << SRC_R0) | (N'(1) << SRC_R1);
    step();
    check("a_heldmulti_err", 32'(a_err), 32'h0);
    check("a_heldmulti_conf", 32'(a_conf), 32'h0);
    a_hold = 1'b0;
    step();
    check("a_r0_bus", a_bus, 32'h000000A5);
    check("a_r0_sel", 32'(a_sel), 32'd0);
    check("a_r0_err", 32'(a_err), 32'h1);
    check("a_r0_cnt", 32'(a_cnt), 32'd1);

    // Narrow counter saturates at 15
    b_clear = 1'b0;
    b_data[SRC_R7*W +: W] = 32'h00007777;
    b_src = N'(1) << SRC_R7;
    exp_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (exp_cnt < 15) exp_cnt++;
      check($sformatf("b_sat_cnt_%0d", i), 32'(b_cnt), 32'(exp_cnt));
    end
    check("b_sat_bus", b_bus, 32'h00007777);
    b_hold = 1'b1;
    b_clear = 1'b1;
    step();
    check("b_clr_bus", b_bus, 32'h0);
    check("b_clr_valid", 32'(b_valid), 32'h0);
    check("b_clr_sel", 32'(b_sel), 32'h0);
    check("b_clr_cnt", 32'(b_cnt), 32'h0);

    // Combinational output path
    c_clear = 1'b0;
    c_data[SRC_C*W +: W] = 32'hFFFFFFF0;
    c_src = N'(1) << SRC_C;
    #1;
    check("c_live_bus", c_bus, 32'hFFFFFFF0);
    check("c_live_valid", 32'(c_valid), 32'h1);
    check("c_live_sel", 32'(c_sel), 32'd23);
    step();
    c_src = '0;
    #1;
    check("c_keep_bus", c_bus, 32'hFFFFFFF0);
    check("c_keep_valid", 32'(c_valid), 32'h0);
    check("c_keep_sel", 32'(c_sel), 32'd23);
    check("c_keep_cnt", 32'(c_cnt), 32'd1);
    c_hold = 1'b1;
    c_data[SRC_INPORT*W +: W] = 32'h00001234;
    c_src = N'(1) << SRC_INPORT;
    #1;
    check("c_hold_bus", c_bus, 32'hFFFFFFF0);
    check("c_hold_valid", 32'(c_valid), 32'h0);
    step();
    check("c_hold_cnt", 32'(c_cnt), 32'd1);
    c_hold = 1'b0;
    c_src = (N'(1) << SRC_R1) | (N'(1) << SRC_R2);
    c_data[SRC_R1*W +: W] = 32'h00000011;
    #1;
    check("c_multi_conf", 32'(c_conf), 32'h1);
    check("c_multi_sel", 32'(c_sel), 32'd1);
    check("c_multi_bus", c_bus, 32'h00000011);
    step();
    check("c_multi_err", 32'(c_err), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
